// File: rtl/prbs4_pkg.sv
`default_nettype none
// prbs4_pkg: shared PRBS-4 (x^4+x^3+1) helpers and checker state encoding.
// Revision: 1.0
package prbs4_pkg;

  localparam int LFSR_W = 4;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } prbs_chk_state_t;

  function automatic logic [LFSR_W-1:0] prbs4_next(input logic [LFSR_W-1:0] s);
    return {s[2:0], s[3] ^ s[2]};
  endfunction

  function automatic logic prbs4_pred(input logic [LFSR_W-1:0] h);
    return h[3] ^ h[2];
  endfunction

endpackage
`default_nettype wire

// File: rtl/prbs4_checker.sv
`default_nettype none
// prbs4_checker: self-synchronising PRBS-4 receive checker with lock and error counting.
// Revision: 1.0
module prbs4_checker
  import prbs4_pkg::*;
#(
  parameter int LOCK_CNT = 8,
  parameter int LOSS_CNT = 4,
  parameter int ERR_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             din,
  input  logic             clr_cnt,
  output logic             locked,
  output logic             err,
  output logic [ERR_W-1:0] err_cnt
);

  localparam logic [3:0] LOCK_LAST = 4'(LOCK_CNT - 1);
  localparam logic [3:0] LOSS_LAST = 4'(LOSS_CNT - 1);

  prbs_chk_state_t   state, state_nxt;
  logic [LFSR_W-1:0] hist, hist_nxt;
  logic [1:0]        fill, fill_nxt;
  logic [3:0]        match, match_nxt;
  logic [3:0]        loss, loss_nxt;
  logic              err_nxt;
  logic [ERR_W-1:0]  err_cnt_nxt;
  logic              pred;

  assign pred = prbs4_pred(hist);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= SEARCH;
      hist    <= '0;
      fill    <= '0;
      match   <= '0;
      loss    <= '0;
      locked  <= 1'b0;
      err     <= 1'b0;
      err_cnt <= '0;
    end else begin
      state   <= state_nxt;
      hist    <= hist_nxt;
      fill    <= fill_nxt;
      match   <= match_nxt;
      loss    <= loss_nxt;
      locked  <= (state_nxt == LOCKED);
      err     <= err_nxt;
      err_cnt <= err_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    hist_nxt    = hist;
    fill_nxt    = fill;
    match_nxt   = match;
    loss_nxt    = loss;
    err_nxt     = 1'b0;
    err_cnt_nxt = err_cnt;

    if (en) begin
      case (state)
        SEARCH: begin
          hist_nxt = {hist[2:0], din};
          if (fill == 2'd3) begin
            state_nxt = VERIFY;
            fill_nxt  = '0;
            match_nxt = '0;
          end else begin
            fill_nxt = fill + 2'd1;
          end
        end
        VERIFY: begin
          hist_nxt = {hist[2:0], din};
          // An all-zero history predicts zero forever, so it must never count as a match.
          if ((din == pred) && (hist != '0)) begin
            if (match == LOCK_LAST) begin
              state_nxt = LOCKED;
              loss_nxt  = '0;
            end else begin
              match_nxt = match + 4'd1;
            end
          end else begin
            match_nxt = '0;
          end
        end
        LOCKED: begin
          // Flywheel on the prediction so a single line error is counted once.
          hist_nxt = {hist[2:0], pred};
          if (din != pred) begin
            err_nxt = 1'b1;
            if (err_cnt != {ERR_W{1'b1}}) begin
              err_cnt_nxt = err_cnt + ERR_W'(1);
            end
            if (loss == LOSS_LAST) begin
              state_nxt = SEARCH;
              fill_nxt  = '0;
              loss_nxt  = '0;
            end else begin
              loss_nxt = loss + 4'd1;
            end
          end else begin
            loss_nxt = '0;
          end
        end
        default: state_nxt = SEARCH;
      endcase
    end

    if (clr_cnt) begin
      err_cnt_nxt = '0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_prbs4_checker.sv
`default_nettype none
// tb_prbs4_checker: randomised and directed checks of prbs4_checker against a behavioural model.
module tb_prbs4_checker;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic        din = 1'b0;
  logic        clr_cnt = 1'b0;
  logic        locked, err;
  logic [15:0] err_cnt;
  logic        locked3, err3;
  logic [2:0]  err_cnt3;

  int n_cmp  = 0;
  int n_fail = 0;
  bit chk_on = 1'b0;

  logic [14:0] pat = 15'b111100010011010;
  int          ph  = 0;

  always #5 clk = ~clk;

  prbs4_checker #(.LOCK_CNT(8), .LOSS_CNT(4), .ERR_W(16)) dut (
    .clk(clk), .rst(rst), .en(en), .din(din), .clr_cnt(clr_cnt),
    .locked(locked), .err(err), .err_cnt(err_cnt)
  );

  prbs4_checker #(.LOCK_CNT(8), .LOSS_CNT(4), .ERR_W(3)) dut3 (
    .clk(clk), .rst(rst), .en(en), .din(din), .clr_cnt(clr_cnt),
    .locked(locked3), .err(err3), .err_cnt(err_cnt3)
  );

  // Reference model: mode 0 = hunting, 1 = verifying, 2 = locked; last four bits kept oldest-first.
  int m_mode, m_seen, m_run, m_bad, m_cnt16, m_cnt3;
  bit m_locked = 1'b0;
  bit m_err = 1'b0;
  bit hq[$];

  always @(posedge clk) begin : model
    bit p, nz;
    m_err = 1'b0;
    if (!rst) begin
      m_mode = 0; m_seen = 0; m_run = 0; m_bad = 0; m_cnt16 = 0; m_cnt3 = 0;
      hq = '{1'b0, 1'b0, 1'b0, 1'b0};
    end else begin
      if (en) begin
        p  = hq[0] ^ hq[1];
        nz = hq[0] | hq[1] | hq[2] | hq[3];
        if (m_mode == 0) begin
          hq.push_back(din);
          m_seen++;
          if (m_seen == 4) begin m_mode = 1; m_run = 0; end
        end else if (m_mode == 1) begin
          hq.push_back(din);
          if (din == p && nz) begin
            m_run++;
            if (m_run == 8) begin m_mode = 2; m_bad = 0; end
          end else m_run = 0;
        end else begin
          hq.push_back(p);
          if (din != p) begin
            m_err = 1'b1;
            if (m_cnt16 < 65535) m_cnt16++;
            if (m_cnt3 < 7) m_cnt3++;
            m_bad++;
            if (m_bad == 4) begin m_mode = 0; m_seen = 0; end
          end else m_bad = 0;
        end
        void'(hq.pop_front());
      end
      if (clr_cnt) begin m_cnt16 = 0; m_cnt3 = 0; end
    end
    m_locked = (m_mode == 2);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      check("locked", 32'(locked), 32'(m_locked));
      check("err", 32'(err), 32'(m_err));
      check("err_cnt", 32'(err_cnt), 32'(m_cnt16));
      check("locked3", 32'(locked3), 32'(m_locked));
      check("err_cnt3", 32'(err_cnt3), 32'(m_cnt3));
    end
  end

  task automatic step(input bit e, input bit d, input bit c);
    en = e; din = d; clr_cnt = c;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input bit inv);
    step(1'b1, pat[14-ph] ^ inv, 1'b0);
    ph = (ph + 1) % 15;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step(1'b1, 1'($urandom_range(1)), 1'b1);
    rst = 1'b1;
    ph  = 0;
  endtask

  initial begin
    int burst;
    burst = 0;

    // Clean stream: lock on the 12th bit, then no errors.
    do_reset();
    chk_on = 1'b1;
    check("rst_locked", 32'(locked), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_err_cnt", 32'(err_cnt), 32'd0);
    for (int k = 1; k <= 200; k++) begin
      send(1'b0);
      if (k == 11) check("t1_not_yet_locked", 32'(locked), 32'd0);
      if (k == 12) check("t1_locked_bit12", 32'(locked), 32'd1);
    end
    check("t1_err_cnt", 32'(err_cnt), 32'd0);

    // Single inverted bit.
    send(1'b1);
    check("t2_err_pulse", 32'(err), 32'd1);
    check("t2_err_cnt", 32'(err_cnt), 32'd1);
    send(1'b0);
    check("t2_err_low", 32'(err), 32'd0);
    check("t2_locked", 32'(locked), 32'd1);
    repeat (5) send(1'b0);

    // Four-bit burst drops lock, resume at a random phase.
    step(1'b0, 1'b0, 1'b1);
    check("t3_cleared", 32'(err_cnt), 32'd0);
    for (int k = 1; k <= 4; k++) begin
      send(1'b1);
      if (k == 3) check("t3_still_locked", 32'(locked), 32'd1);
    end
    check("t3_lock_lost", 32'(locked), 32'd0);
    check("t3_err_cnt", 32'(err_cnt), 32'd4);
    ph = $urandom_range(14);
    for (int k = 1; k <= 12; k++) begin
      send(1'b0);
      if (k == 11) check("t3_not_relocked", 32'(locked), 32'd0);
      if (k == 12) check("t3_relocked", 32'(locked), 32'd1);
    end
    check("t3_err_cnt_kept", 32'(err_cnt), 32'd4);

    // All-zero stream never locks.
    do_reset();
    repeat (100) step(1'b1, 1'b0, 1'b0);
    check("t4_zero_unlocked", 32'(locked), 32'd0);
    check("t4_zero_err_cnt", 32'(err_cnt), 32'd0);

    // Enable on alternate cycles with junk data in the gaps.
    do_reset();
    for (int k = 1; k <= 32; k++) begin
      step(1'b0, 1'($urandom_range(1)), 1'b0);
      send(1'b0);
      if (k == 11) check("t5_not_yet_locked", 32'(locked), 32'd0);
      if (k == 12) check("t5_locked_bit12", 32'(locked), 32'd1);
    end
    check("t5_err_cnt", 32'(err_cnt), 32'd0);

    // Ten isolated errors saturate the 3-bit counter.
    for (int k = 0; k < 10; k++) begin
      send(1'b1);
      repeat (3) send(1'b0);
    end
    check("t6_err_cnt16", 32'(err_cnt), 32'd10);
    check("t6_err_cnt3_sat", 32'(err_cnt3), 32'd7);
    check("t6_locked", 32'(locked), 32'd1);

    // Clear coincident with an error: count 0, pulse still fires.
    step(1'b1, pat[14-ph] ^ 1'b1, 1'b1);
    ph = (ph + 1) % 15;
    check("t6_clr_err_pulse", 32'(err), 32'd1);
    check("t6_clr_err_cnt", 32'(err_cnt), 32'd0);
    repeat (3) send(1'b0);
    send(1'b1);

    // Reset while locked.
    rst = 1'b0;
    step(1'b1, 1'b0, 1'b0);
    check("t6_rst_locked", 32'(locked), 32'd0);
    check("t6_rst_err_cnt", 32'(err_cnt), 32'd0);
    rst = 1'b1;

    // Randomised soak with gaps, sparse errors, bursts, clears and resets.
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(699) == 0) begin
        rst = 1'b0;
        step(1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)));
        rst = 1'b1;
      end else begin
        if ($urandom_range(249) == 0) burst = 5;
        if ($urandom_range(3) == 0) begin
          step(1'b0, 1'($urandom_range(1)), $urandom_range(99) == 0);
        end else begin
          step(1'b1, pat[14-ph] ^ ((burst > 0) || ($urandom_range(39) == 0)),
               $urandom_range(199) == 0);
          if (burst > 0) burst--;
          ph = (ph + 1) % 15;
        end
      end
    end

    @(negedge clk);
    chk_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
